// File: rtl/reg_file_sb.sv
// Purpose : multi-read-port integer register file with busy-bit scoreboard and
//           optional same-cycle writeback-to-read forwarding (decode/writeback).
// Latency : reads are combinational (0 cycles); writes and busy updates land at
//           the next rising clk edge. No backpressure: every request is accepted.
// Ports   : clk, rst (async, active-high)
//           wen/waddr/wdata      writeback port; clears busy[waddr]
//           iss_valid/iss_rd     issue port; sets busy[iss_rd]
//           flush                clears every busy bit
//           raddr/rdata/rbusy    RD_PORTS packed read ports (port i at slice i)
//           busy_vec             registered scoreboard, bit n = register n busy
module reg_file_sb #(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter int RD_PORTS = 2,
  parameter int BYPASS   = 1,
  parameter int R0_ZERO  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wen,
  input  logic [AW-1:0]            waddr,
  input  logic [XLEN-1:0]          wdata,
  input  logic                     iss_valid,
  input  logic [AW-1:0]            iss_rd,
  input  logic                     flush,
  input  logic [RD_PORTS*AW-1:0]   raddr,
  output logic [RD_PORTS*XLEN-1:0] rdata,
  output logic [RD_PORTS-1:0]      rbusy,
  output logic [(1<<AW)-1:0]       busy_vec
);

  localparam int NREGS = 1 << AW;

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  logic wr_ok;
  logic iss_ok;
  logic fwd_en;

  // Writes and issues aimed at a hardwired-zero x0 are dropped entirely.
  assign wr_ok  = wen && !((R0_ZERO != 0) && (waddr == '0));
  assign iss_ok = iss_valid && !((R0_ZERO != 0) && (iss_rd == '0));
  // Forwarding is suppressed while rst is held so every read port shows 0
  // during reset, even if a writeback happens to be presented.
  assign fwd_en = (BYPASS != 0) && wr_ok && !rst;

  always_comb begin
    regs_d = regs_q;
    if (wr_ok) begin
      regs_d[waddr] = wdata;
    end
  end

  // Clear first, then set, so a new writer issued in the same cycle the old
  // one retires keeps the register busy. Flush overrides both, including the
  // issue presented alongside it.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (wen) begin
        busy_d[waddr] = 1'b0;
      end
      if (iss_ok) begin
        busy_d[iss_rd] = 1'b1;
      end
    end
    if (R0_ZERO != 0) begin
      busy_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < NREGS; n++) begin
        regs_q[n] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

  for (genvar i = 0; i < RD_PORTS; i++) begin : g_rd
    logic [AW-1:0] ra;
    logic          r0_hit;
    logic          fwd_hit;

    assign ra      = raddr[i*AW +: AW];
    assign r0_hit  = (R0_ZERO != 0) && (ra == '0);
    assign fwd_hit = fwd_en && (waddr == ra);

    assign rdata[i*XLEN +: XLEN] = r0_hit  ? '0    :
                                   fwd_hit ? wdata :
                                             regs_q[ra];
    // The retiring writeback is forwarded, so its operand is ready now.
    assign rbusy[i] = busy_q[ra] & ~fwd_hit;
  end

endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;

  logic        clk;
  logic        rst;
  logic        wen;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        flush;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  rbusy;
  logic [31:0] busy_vec;
  logic [63:0] nb_rdata;
  logic [1:0]  nb_rbusy;
  logic [31:0] nb_busy_vec;

  int n_vec;
  int n_err;

  reg_file_sb #(.XLEN(32), .AW(5), .RD_PORTS(2), .BYPASS(1), .R0_ZERO(1)) dut (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .flush(flush),
    .raddr(raddr), .rdata(rdata), .rbusy(rbusy), .busy_vec(busy_vec)
  );

  reg_file_sb #(.XLEN(32), .AW(5), .RD_PORTS(2), .BYPASS(0), .R0_ZERO(1)) dut_nb (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .flush(flush),
    .raddr(raddr), .rdata(nb_rdata), .rbusy(nb_rbusy), .busy_vec(nb_busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wen = 1'b0; iss_valid = 1'b0; flush = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1; idle();
    waddr = '0; wdata = '0; iss_rd = '0; raddr = '0;
    #2;
    chk("rst_busy_vec", {32'h0, busy_vec}, 64'h0);
    chk("rst_rdata", rdata, 64'h0);
    chk("rst_rbusy", {62'h0, rbusy}, 64'h0);
    @(negedge clk); rst = 1'b0;

    // T1: preload x5, mark it busy, then reset asynchronously mid-cycle.
    tick();
    wen = 1'b1; waddr = 5'd5; wdata = 32'hDEAD;
    tick();
    idle(); raddr[4:0] = 5'd5; raddr[9:5] = 5'd5;
    iss_valid = 1'b1; iss_rd = 5'd5;
    #1;
    chk("t1_preload", rdata, {32'hDEAD, 32'hDEAD});
    tick();
    idle();
    chk("t1_busy5", {32'h0, busy_vec}, 64'h20);
    #2 rst = 1'b1;
    #1;
    chk("t1_async_rdata", rdata, 64'h0);
    chk("t1_async_busy", {32'h0, busy_vec}, 64'h0);
    chk("t1_async_nb_rdata", nb_rdata, 64'h0);
    @(negedge clk); rst = 1'b0;

    // T2: x0 ignores writes and issues.
    tick();
    wen = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF;
    iss_valid = 1'b1; iss_rd = 5'd0; raddr = '0;
    #1;
    chk("t2_x0_fwd", rdata, 64'h0);
    tick();
    idle();
    #1;
    chk("t2_x0_rdata", rdata, 64'h0);
    chk("t2_x0_busy", {32'h0, busy_vec}, 64'h0);

    // T3: forwarding vs. array-only on both ports.
    wen = 1'b1; waddr = 5'd7; wdata = 32'h1111;
    tick();
    wdata = 32'h1234; raddr[4:0] = 5'd7; raddr[9:5] = 5'd7;
    #1;
    chk("t3_byp", rdata, {32'h1234, 32'h1234});
    chk("t3_nobyp_old", nb_rdata, {32'h1111, 32'h1111});
    tick();
    idle();
    #1;
    chk("t3_nobyp_next", nb_rdata, {32'h1234, 32'h1234});

    // T4: issue marks busy next cycle; writeback clears with forwarding.
    iss_valid = 1'b1; iss_rd = 5'd9; raddr[4:0] = 5'd9; raddr[9:5] = 5'd0;
    #1;
    chk("t4_rbusy_same", {62'h0, rbusy}, 64'h0);
    tick();
    idle();
    #1;
    chk("t4_busy_vec", {32'h0, busy_vec}, 64'h200);
    chk("t4_rbusy", {62'h0, rbusy}, 64'h1);
    wen = 1'b1; waddr = 5'd9; wdata = 32'h55;
    #1;
    chk("t4_wb_rbusy", {62'h0, rbusy}, 64'h0);
    chk("t4_wb_rdata", rdata, {32'h0, 32'h55});
    chk("t4_nb_rbusy", {62'h0, nb_rbusy}, 64'h1);
    tick();
    idle();
    #1;
    chk("t4_cleared", {32'h0, busy_vec}, 64'h0);
    chk("t4_array", rdata, {32'h0, 32'h55});

    // T5: same-cycle retire and reissue of x3 keeps it busy.
    iss_valid = 1'b1; iss_rd = 5'd3;
    tick();
    wen = 1'b1; waddr = 5'd3; wdata = 32'hABC;
    iss_valid = 1'b1; iss_rd = 5'd3;
    tick();
    idle(); raddr[4:0] = 5'd3;
    #1;
    chk("t5_busy3", {32'h0, busy_vec}, 64'h8);
    chk("t5_data3", rdata, {32'h0, 32'hABC});

    // T6: flush beats a concurrent issue but the write still lands.
    iss_valid = 1'b1; iss_rd = 5'd1; tick();
    iss_rd = 5'd2; tick();
    iss_rd = 5'd4; tick();
    idle();
    chk("t6_pre", {32'h0, busy_vec}, 64'h1E);
    flush = 1'b1; iss_valid = 1'b1; iss_rd = 5'd6;
    wen = 1'b1; waddr = 5'd2; wdata = 32'h77;
    tick();
    idle(); raddr[4:0] = 5'd2; raddr[9:5] = 5'd6;
    #1;
    chk("t6_flushed", {32'h0, busy_vec}, 64'h0);
    chk("t6_nb_flushed", {32'h0, nb_busy_vec}, 64'h0);
    chk("t6_rbusy", {62'h0, rbusy}, 64'h0);
    chk("t6_write", rdata, {32'h0, 32'h77});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
